// File: rtl/keypad_scanner_if.sv
// Keypad scanner bus: matrix-side row/column lines plus the clean key event outputs.
//   row_in     keypad rows, active-low, asynchronous to the scanner clock
//   col_drive  column drive, active-low one-hot
//   key        last accepted key code {row_idx, col_idx}
//   key_valid  1-cycle pulse on every accepted key
//   shift      1-cycle pulse when the accepted key is a digit (0..9)
//   alarm_req  1-cycle pulse for code 10
//   time_req   1-cycle pulse for code 11
//   key_down   level, high while a key is held
// master: the scanner. slave: the consumer side (keypad model plus key register).
interface keypad_scanner_if;
  logic [3:0] row_in;
  logic [3:0] col_drive;
  logic [3:0] key;
  logic       key_valid;
  logic       shift;
  logic       alarm_req;
  logic       time_req;
  logic       key_down;

  modport master (
    input  row_in,
    output col_drive, key, key_valid, shift, alarm_req, time_req, key_down
  );

  modport slave (
    output row_in,
    input  col_drive, key, key_valid, shift, alarm_req, time_req, key_down
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner and debouncer. Drives one column at a time, samples the
// synchronised rows every SCAN_DIV clocks and debounces press and release over
// DEBOUNCE_CNT samples. Each accepted press produces one key_valid pulse plus the
// decoded shift/alarm_req/time_req pulse; nothing repeats while the key is held.
// Ports:
//   clock  system clock
//   reset  asynchronous, active-high
//   bus    keypad_scanner_if.master (row_in in; col_drive, key, strobes, key_down out)
module keypad_scanner #(
  parameter int unsigned SCAN_DIV     = 4,  // 4..255
  parameter int unsigned DEBOUNCE_CNT = 3   // 1..15
) (
  input  logic             clock,
  input  logic             reset,
  keypad_scanner_if.master bus
);

  typedef enum logic [1:0] {StScan, StDebounce, StHeld} state_e;

  state_e     state_q, state_d;
  logic [3:0] row_s1_q, row_s2_q;
  logic [7:0] div_cnt_q;
  logic [1:0] col_sel_q, col_sel_d;
  logic [3:0] code_q, code_d;
  logic [3:0] match_q, match_d;
  logic [3:0] rel_q, rel_d;
  logic [3:0] key_q;
  logic       key_valid_q, shift_q, alarm_q, time_q;

  logic       sample;
  logic       hit;
  logic [1:0] row_idx;
  logic [3:0] cur_code;
  logic [3:0] match_inc;
  logic [3:0] rel_inc;
  logic       accept;

  assign sample    = (div_cnt_q == 8'(SCAN_DIV - 1));
  assign cur_code  = {row_idx, col_sel_q};
  assign match_inc = match_q + 4'd1;
  assign rel_inc   = rel_q + 4'd1;

  // Exactly one row low is a hit; no-press and multi-row (ghosting) patterns are not.
  always_comb begin
    hit     = 1'b0;
    row_idx = 2'd0;
    unique case (row_s2_q)
      4'b1110: begin hit = 1'b1; row_idx = 2'd0; end
      4'b1101: begin hit = 1'b1; row_idx = 2'd1; end
      4'b1011: begin hit = 1'b1; row_idx = 2'd2; end
      4'b0111: begin hit = 1'b1; row_idx = 2'd3; end
      default: begin hit = 1'b0; row_idx = 2'd0; end
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StScan;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and counter logic; the column only moves on samples in SCAN or on leaving.
  always_comb begin
    state_d   = state_q;
    col_sel_d = col_sel_q;
    code_d    = code_q;
    match_d   = match_q;
    rel_d     = rel_q;
    accept    = 1'b0;
    if (sample) begin
      unique case (state_q)
        StScan: begin
          if (hit) begin
            code_d  = cur_code;
            match_d = 4'd1;
            if (DEBOUNCE_CNT == 1) begin
              accept  = 1'b1;
              match_d = 4'd0;
              state_d = StHeld;
            end else begin
              state_d = StDebounce;
            end
          end else begin
            col_sel_d = col_sel_q + 2'd1;
          end
        end
        StDebounce: begin
          if (hit && (cur_code == code_q)) begin
            match_d = match_inc;
            if (match_inc == 4'(DEBOUNCE_CNT)) begin
              accept  = 1'b1;
              match_d = 4'd0;
              state_d = StHeld;
            end
          end else begin
            match_d   = 4'd0;
            col_sel_d = col_sel_q + 2'd1;
            state_d   = StScan;
          end
        end
        StHeld: begin
          if (row_s2_q == 4'hF) begin
            rel_d = rel_inc;
            if (rel_inc == 4'(DEBOUNCE_CNT)) begin
              rel_d     = 4'd0;
              col_sel_d = col_sel_q + 2'd1;
              state_d   = StScan;
            end
          end else begin
            rel_d = 4'd0;
          end
        end
        default: state_d = StScan;
      endcase
    end
  end

  // Datapath: synchroniser, divider, counters and registered event outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row_s1_q    <= 4'hF;
      row_s2_q    <= 4'hF;
      div_cnt_q   <= 8'd0;
      col_sel_q   <= 2'd0;
      code_q      <= 4'd0;
      match_q     <= 4'd0;
      rel_q       <= 4'd0;
      key_q       <= 4'd0;
      key_valid_q <= 1'b0;
      shift_q     <= 1'b0;
      alarm_q     <= 1'b0;
      time_q      <= 1'b0;
    end else begin
      row_s1_q    <= bus.row_in;
      row_s2_q    <= row_s1_q;
      div_cnt_q   <= sample ? 8'd0 : div_cnt_q + 8'd1;
      col_sel_q   <= col_sel_d;
      code_q      <= code_d;
      match_q     <= match_d;
      rel_q       <= rel_d;
      key_valid_q <= accept;
      shift_q     <= accept && (cur_code < 4'd10);
      alarm_q     <= accept && (cur_code == 4'd10);
      time_q      <= accept && (cur_code == 4'd11);
      if (accept) begin
        key_q <= cur_code;
      end
    end
  end

  // Outputs.
  always_comb begin
    bus.col_drive = ~(4'b0001 << col_sel_q);
    bus.key_down  = (state_q == StHeld);
    bus.key       = key_q;
    bus.key_valid = key_valid_q;
    bus.shift     = shift_q;
    bus.alarm_req = alarm_q;
    bus.time_req  = time_q;
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed self-checking bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_CNT=3).
// A behavioural 4x4 matrix drives row_in from col_drive and the set of pressed keys.
module tb_keypad_scanner;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  keypad_scanner_if bus ();

  keypad_scanner #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CNT (3)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // pressed[c][r] = 1 means the switch at row r, column c is closed.
  logic [3:0] pressed [4];
  logic [3:0] rows;
  always_comb begin
    rows = 4'hF;
    for (int c = 0; c < 4; c++) begin
      if (!bus.col_drive[c]) rows = rows & ~pressed[c];
    end
  end
  assign bus.row_in = rows;

  int errors = 0;
  int checks = 0;

  int         kv_cnt, sh_cnt, al_cnt, tm_cnt, col_changes;
  logic [3:0] kv_key;
  logic [3:0] prev_col;
  logic [15:0] kbuf;  // model of the downstream 4-digit key shift register

  task automatic release_all();
    for (int c = 0; c < 4; c++) pressed[c] = 4'h0;
  endtask

  task automatic press(input int r, input int c);
    release_all();
    pressed[c][r] = 1'b1;
  endtask

  task automatic clear_counts();
    kv_cnt      = 0;
    sh_cnt      = 0;
    al_cnt      = 0;
    tm_cnt      = 0;
    col_changes = 0;
    kv_key      = 4'hx;
    prev_col    = bus.col_drive;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (bus.key_valid) begin kv_cnt++; kv_key = bus.key; end
      if (bus.shift) begin sh_cnt++; kbuf = {kbuf[11:0], bus.key}; end
      if (bus.alarm_req) al_cnt++;
      if (bus.time_req) tm_cnt++;
      if (bus.col_drive !== prev_col) col_changes++;
      prev_col = bus.col_drive;
    end
  endtask

  task automatic test_reset();
    logic [3:0] prev;
    int         since;
    bit         seen_first;
    bit         pulse_seen;
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.col_drive !== 4'b1110)
      $display("FAIL reset_col_drive: got %b want 1110", bus.col_drive);
    if (bus.col_drive !== 4'b1110) errors++;
    checks++;
    if (bus.key !== 4'h0) begin
      $display("FAIL reset_key: got %h want 0", bus.key); errors++;
    end
    checks++;
    if ({bus.key_valid, bus.shift, bus.alarm_req, bus.time_req, bus.key_down} !== 5'b0) begin
      $display("FAIL reset_strobes: got %b want 00000",
               {bus.key_valid, bus.shift, bus.alarm_req, bus.time_req, bus.key_down});
      errors++;
    end
    reset = 1'b0;
    prev = bus.col_drive;
    since = 0;
    seen_first = 0;
    pulse_seen = 0;
    for (int i = 0; i < 48; i++) begin
      @(negedge clock);
      since++;
      if (bus.key_valid || bus.shift || bus.alarm_req || bus.time_req || bus.key_down)
        pulse_seen = 1;
      if (bus.col_drive !== prev) begin
        checks++;
        if (bus.col_drive !== {prev[2:0], prev[3]}) begin
          $display("FAIL idle_col_order: got %b want %b", bus.col_drive, {prev[2:0], prev[3]});
          errors++;
        end
        if (seen_first) begin
          checks++;
          if (since !== 4) begin
            $display("FAIL idle_col_dwell: got %0d want 4", since); errors++;
          end
        end
        seen_first = 1;
        since = 0;
        prev = bus.col_drive;
      end
    end
    checks++;
    if (pulse_seen !== 1'b0) begin
      $display("FAIL idle_no_pulse: got %b want 0", pulse_seen); errors++;
    end
  endtask

  task automatic test_digit();
    clear_counts();
    press(1, 2);
    run(80);
    checks++;
    if (kv_cnt !== 1) begin $display("FAIL digit_kv_count: got %0d want 1", kv_cnt); errors++; end
    checks++;
    if (kv_key !== 4'd6) begin $display("FAIL digit_key: got %h want 6", kv_key); errors++; end
    checks++;
    if ({sh_cnt, al_cnt, tm_cnt} !== {32'd1, 32'd0, 32'd0}) begin
      $display("FAIL digit_decode: shift=%0d alarm=%0d time=%0d want 1 0 0", sh_cnt, al_cnt,
               tm_cnt);
      errors++;
    end
    run(40);
    checks++;
    if (kv_cnt !== 1 || bus.key_down !== 1'b1) begin
      $display("FAIL digit_held: kv=%0d key_down=%b want 1 1", kv_cnt, bus.key_down); errors++;
    end
    release_all();
    run(6);
    checks++;
    if (bus.key_down !== 1'b1) begin
      $display("FAIL digit_release_early: key_down=%b want 1", bus.key_down); errors++;
    end
    run(30);
    checks++;
    if (bus.key_down !== 1'b0) begin
      $display("FAIL digit_released: key_down=%b want 0", bus.key_down); errors++;
    end
    clear_counts();
    run(20);
    checks++;
    if (col_changes < 4) begin
      $display("FAIL digit_scan_resumes: changes=%0d want >=4", col_changes); errors++;
    end
  endtask

  task automatic test_bounce();
    clear_counts();
    for (int i = 0; i < 25; i++) begin
      press(2, 2);
      run(4);
      release_all();
      run(4);
    end
    checks++;
    if (kv_cnt !== 0) begin $display("FAIL bounce_no_accept: got %0d want 0", kv_cnt); errors++; end
    checks++;
    if (bus.key !== 4'd6) begin $display("FAIL bounce_key_kept: got %h want 6", bus.key); errors++; end
    clear_counts();
    press(2, 2);
    run(80);
    checks++;
    if (kv_cnt !== 1 || kv_key !== 4'd10) begin
      $display("FAIL alarm_key: kv=%0d key=%h want 1 a", kv_cnt, kv_key); errors++;
    end
    checks++;
    if (al_cnt !== 1 || sh_cnt !== 0 || tm_cnt !== 0) begin
      $display("FAIL alarm_decode: alarm=%0d shift=%0d time=%0d want 1 0 0", al_cnt, sh_cnt,
               tm_cnt);
      errors++;
    end
    release_all();
    run(40);
  endtask

  task automatic test_multi_row();
    release_all();
    pressed[1] = 4'b0011;
    clear_counts();
    run(100);
    checks++;
    if (kv_cnt !== 0) begin $display("FAIL multi_no_accept: got %0d want 0", kv_cnt); errors++; end
    checks++;
    if (col_changes < 20) begin
      $display("FAIL multi_scanning: changes=%0d want >=20", col_changes); errors++;
    end
    release_all();
    run(8);
    clear_counts();
    press(3, 0);
    run(80);
    checks++;
    if (kv_cnt !== 1 || kv_key !== 4'd12) begin
      $display("FAIL code12_key: kv=%0d key=%h want 1 c", kv_cnt, kv_key); errors++;
    end
    checks++;
    if (sh_cnt + al_cnt + tm_cnt !== 0) begin
      $display("FAIL code12_decode: strobes=%0d want 0", sh_cnt + al_cnt + tm_cnt); errors++;
    end
    release_all();
    run(40);
    clear_counts();
    press(2, 3);
    run(80);
    checks++;
    if (kv_cnt !== 1 || kv_key !== 4'd11 || tm_cnt !== 1 || sh_cnt !== 0 || al_cnt !== 0) begin
      $display("FAIL time_decode: kv=%0d key=%h time=%0d shift=%0d alarm=%0d want 1 b 1 0 0",
               kv_cnt, kv_key, tm_cnt, sh_cnt, al_cnt);
      errors++;
    end
    release_all();
    run(40);
  endtask

  task automatic test_long_hold();
    clear_counts();
    press(0, 3);
    run(880);
    checks++;
    if (kv_cnt !== 1 || kv_key !== 4'd3) begin
      $display("FAIL long_hold_once: kv=%0d key=%h want 1 3", kv_cnt, kv_key); errors++;
    end
    // Two high samples, one low, then steady high: only the last run of three counts.
    release_all();
    run(8);
    press(0, 3);
    run(4);
    release_all();
    run(6);
    checks++;
    if (bus.key_down !== 1'b1) begin
      $display("FAIL release_bounce_held: key_down=%b want 1", bus.key_down); errors++;
    end
    run(20);
    checks++;
    if (bus.key_down !== 1'b0) begin
      $display("FAIL release_bounce_done: key_down=%b want 0", bus.key_down); errors++;
    end
    checks++;
    if (kv_cnt !== 1) begin $display("FAIL release_no_repeat: kv=%0d want 1", kv_cnt); errors++; end
  endtask

  task automatic test_reset_mid();
    // Reset while debouncing code 0 (column 0 is driven straight out of reset).
    reset = 1'b1;
    press(0, 0);
    run(2);
    reset = 1'b0;
    clear_counts();
    run(6);
    reset = 1'b1;
    run(2);
    checks++;
    if (kv_cnt !== 0 || bus.col_drive !== 4'b1110 || bus.key !== 4'h0 || bus.key_down !== 1'b0)
    begin
      $display("FAIL reset_in_debounce: kv=%0d col=%b key=%h down=%b want 0 1110 0 0", kv_cnt,
               bus.col_drive, bus.key, bus.key_down);
      errors++;
    end
    reset = 1'b0;
    clear_counts();
    run(30);
    checks++;
    if (kv_cnt !== 1 || kv_key !== 4'd0 || sh_cnt !== 1) begin
      $display("FAIL redetect_after_debounce_reset: kv=%0d key=%h shift=%0d want 1 0 1", kv_cnt,
               kv_key, sh_cnt);
      errors++;
    end
    release_all();
    run(40);
    // Reset while holding code 5.
    press(1, 1);
    clear_counts();
    run(80);
    checks++;
    if (kv_cnt !== 1 || bus.key !== 4'd5 || bus.key_down !== 1'b1) begin
      $display("FAIL held_before_reset: kv=%0d key=%h down=%b want 1 5 1", kv_cnt, bus.key,
               bus.key_down);
      errors++;
    end
    reset = 1'b1;
    clear_counts();
    run(2);
    checks++;
    if (kv_cnt !== 0 || bus.key !== 4'h0 || bus.key_down !== 1'b0 || bus.col_drive !== 4'b1110)
    begin
      $display("FAIL reset_in_held: kv=%0d key=%h down=%b col=%b want 0 0 0 1110", kv_cnt,
               bus.key, bus.key_down, bus.col_drive);
      errors++;
    end
    reset = 1'b0;
    clear_counts();
    run(80);
    checks++;
    if (kv_cnt !== 1 || kv_key !== 4'd5) begin
      $display("FAIL redetect_after_held_reset: kv=%0d key=%h want 1 5", kv_cnt, kv_key);
      errors++;
    end
    release_all();
    run(40);
  endtask

  task automatic test_back_to_back();
    logic [3:0] digits [4];
    digits[0] = 4'd1;
    digits[1] = 4'd2;
    digits[2] = 4'd3;
    digits[3] = 4'd4;
    kbuf = 16'h0;
    for (int i = 0; i < 4; i++) begin
      press(int'(digits[i][3:2]), int'(digits[i][1:0]));
      run(80);
      release_all();
      run(40);
    end
    checks++;
    if (kbuf !== 16'h1234) begin
      $display("FAIL keyreg_order: got %h want 1234", kbuf); errors++;
    end
  endtask

  initial begin
    release_all();
    kbuf = 16'h0;
    clear_counts();
    test_reset();
    test_digit();
    test_bounce();
    test_multi_row();
    test_long_hold();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
